// File: rtl/dot_product_collector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_product_collector_pkg : shared width helpers for the collector |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dot_product_collector_pkg;

    // Index fields keep at least one bit, even when a dimension is 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed FIFO entry layout: {data, row, col, last}.
    function automatic int entry_width(input int res_width, input int rows, input int cols);
        return res_width + idx_width(rows) + idx_width(cols) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_product_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_product_collector_if : engine-side capture and drain stream    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dot_product_collector_if
    import dot_product_collector_pkg::*;
#(
    parameter int RES_WIDTH = 67,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int DEPTH     = 16
);
    localparam int RW   = idx_width(ROWS);
    localparam int CW   = idx_width(COLS);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic                 clear;
    logic                 readEn;
    logic [RES_WIDTH-1:0] DotProduct;
    logic                 out_valid;
    logic                 out_ready;
    logic [RES_WIDTH-1:0] out_data;
    logic [RW-1:0]        out_row;
    logic [CW-1:0]        out_col;
    logic                 out_last;
    logic                 full;
    logic                 overflow;
    logic [CNTW-1:0]      count;

    modport master (
        output clear, readEn, DotProduct, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last, full, overflow, count
    );

    modport slave (
        input  clear, readEn, DotProduct, out_ready,
        output out_valid, out_data, out_row, out_col, out_last, full, overflow, count
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_collector_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | result_fifo : first-word fall-through FIFO with flush              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clear,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         wr_data,
    output logic      [WIDTH-1:0]         rd_data,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             w_pop_fire;
    logic             w_push_fire;

    assign empty = (count_q == '0);
    assign full  = (count_q == C_FULL_COUNT);
    assign count = count_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop_fire  = pop & ~empty & ~clear;
    assign w_push_fire = push & (~full | w_pop_fire) & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_push_fire, w_pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/dot_product_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_product_collector : tags engine results with (row,col), buffers|
// | them and drains them over a valid/ready stream.  Rev 1.0           |
// +--------------------------------------------------------------------+
module dot_product_collector
    import dot_product_collector_pkg::*;
#(
    parameter int RES_WIDTH = 67,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int DEPTH     = 16
) (
    input  wire logic             Clock,
    input  wire logic             Reset_n,
    dot_product_collector_if.slave bus
);
    localparam int RW   = idx_width(ROWS);
    localparam int CW   = idx_width(COLS);
    localparam int EW   = entry_width(RES_WIDTH, ROWS, COLS);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [RW-1:0] C_ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_COL_MAX = CW'(COLS - 1);

    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            overflow_q, overflow_d;
    logic            w_last;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [EW-1:0]   w_wr_entry;
    logic [EW-1:0]   w_head;
    logic [CNTW-1:0] w_count;

    assign w_last     = (row_q == C_ROW_MAX) && (col_q == C_COL_MAX);
    assign w_pop      = bus.out_ready & ~w_empty;
    assign w_wr_entry = {bus.DotProduct, row_q, col_q, w_last};

    // Indices advance on every readEn, dropped or not, so positions stay aligned.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        overflow_d = overflow_q;
        if (bus.clear) begin
            row_d      = '0;
            col_d      = '0;
            overflow_d = 1'b0;
        end else if (bus.readEn) begin
            if (col_q == C_COL_MAX) begin
                col_d = '0;
                row_d = (row_q == C_ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (w_full && !w_pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            row_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
        end
    end

    result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .clear   (bus.clear),
        .push    (bus.readEn),
        .pop     (bus.out_ready),
        .wr_data (w_wr_entry),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Head fields are forced to zero while empty so outputs are clean out of reset.
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head[EW-1 -: RES_WIDTH];
    assign bus.out_row   = w_empty ? '0 : w_head[RW+CW -: RW];
    assign bus.out_col   = w_empty ? '0 : w_head[CW -: CW];
    assign bus.out_last  = w_empty ? 1'b0 : w_head[0];
    assign bus.full      = w_full;
    assign bus.overflow  = overflow_q;
    assign bus.count     = w_count;

endmodule
`default_nettype wire
